// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide sequencer.
// Op and state encodings, latency defaults, small arithmetic helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_CNT_W       = 5;
  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  function automatic logic [31:0] md_neg(
    input logic [31:0] v
  );
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_latency_counter.sv
// Down-counter modelling the multi-cycle latency of the HI/LO unit.
// Loads a cycle count, decrements while enabled, flags the final cycle.
module muldiv_latency_counter
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [MD_CNT_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic [MD_CNT_W-1:0] count_o,
  output logic                last_o
);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;

  // Load wins over decrement; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign last_o  = (cnt_q == MD_CNT_W'(1));

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the 5-stage pipeline.
// Result computed at start, held for a fixed latency, then committed.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_mul_div,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MD_CNT_W-1:0] MUL_LAT = MD_CNT_W'(MUL_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LAT = MD_CNT_W'(DIV_CYCLES);

  md_state_e   state_q;
  logic [31:0] pend_hi_q;
  logic [31:0] pend_lo_q;
  logic        div0_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        go;
  logic        wh;
  logic        wl;
  md_op_e      op_e;
  logic        is_div;
  logic        is_sgn;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [63:0] res;

  logic                cnt_load;
  logic [MD_CNT_W-1:0] cnt_val;
  logic [MD_CNT_W-1:0] cnt;
  logic                cnt_last;

  // Start beats mt_*; kill cancels anything issuing from E.
  assign go = start & ~kill;
  assign wh = mt_hi & ~kill & ~start;
  assign wl = mt_lo & ~kill & ~start;

  assign op_e   = md_op_e'(op);
  assign is_div = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign is_sgn = (op_e == MD_MULT) || (op_e == MD_DIV);

  // Product and sign-magnitude divide, all sampled from a/b on go.
  always_comb begin
    a_ext = {{32{is_sgn & a[31]}}, a};
    b_ext = {{32{is_sgn & b[31]}}, b};
    prod  = a_ext * b_ext;

    a_neg = (op_e == MD_DIV) && a[31];
    b_neg = (op_e == MD_DIV) && b[31];
    a_mag = a_neg ? md_neg(a) : a;
    b_mag = b_neg ? md_neg(b) : b;
    b_div = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    q_res = (a_neg ^ b_neg) ? md_neg(q_mag) : q_mag;
    r_res = a_neg ? md_neg(r_mag) : r_mag;

    res = is_div ? {r_res, q_res} : prod;
  end

  assign cnt_load = (state_q == MD_IDLE) && go;
  assign cnt_val  = is_div ? DIV_LAT : MUL_LAT;

  muldiv_latency_counter u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (busy),
    .count_o    (cnt),
    .last_o     (cnt_last)
  );

  // Sequencer: latch result on go, commit to HI/LO on the last busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (go) begin
            pend_hi_q <= res[63:32];
            pend_lo_q <= res[31:0];
            div0_q    <= is_div && (b == 32'd0);
            state_q   <= MD_BUSY;
          end else begin
            if (wh) hi_q <= a;
            if (wl) lo_q <= a;
          end
        end
        MD_BUSY: begin
          if (cnt_last) begin
            if (!div0_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= MD_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (state_q == MD_BUSY);
  assign done  = busy & cnt_last;
  assign stall = d_mul_div & (start | busy);
  assign hi    = hi_q;
  assign lo    = lo_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus corner sequences.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        mt_hi;
  logic        mt_lo;
  logic        kill;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_mul_div;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d;
    logic        kmid;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[7];

  muldiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .mt_hi     (mt_hi),
    .mt_lo     (mt_lo),
    .kill      (kill),
    .a         (a),
    .b         (b),
    .d_mul_div (d_mul_div),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int n;
    n = v.op[1] ? 10 : 5;
    step();
    start = 1'b1; op = v.op; a = v.a; b = v.b; d_mul_div = v.d;
    @(negedge clk);
    chk({v.nm, ".stall0"}, 64'(stall), 64'(v.d));
    chk({v.nm, ".busy0"}, 64'(busy), 64'd0);
    for (int c = 1; c <= n; c++) begin
      step();
      start = 1'b0;
      a = 32'hA5A5A5A5;
      b = 32'h5A5A5A5A;
      kill = v.kmid && (c == 2);
      @(negedge clk);
      chk($sformatf("%s.busy%0d", v.nm, c), 64'(busy), 64'd1);
      chk($sformatf("%s.done%0d", v.nm, c), 64'(done), 64'(c == n));
      chk($sformatf("%s.stall%0d", v.nm, c), 64'(stall), 64'(v.d));
    end
    step();
    kill = 1'b0;
    @(negedge clk);
    chk({v.nm, ".busy_end"}, 64'(busy), 64'd0);
    chk({v.nm, ".done_end"}, 64'(done), 64'd0);
    chk({v.nm, ".stall_end"}, 64'(stall), 64'd0);
    chk({v.nm, ".hi"}, 64'(hi), 64'(v.eh));
    chk({v.nm, ".lo"}, 64'(lo), 64'(v.el));
    d_mul_div = 1'b0;
  endtask

  task automatic mt(input logic h, input logic [31:0] val, input logic k);
    step();
    mt_hi = h; mt_lo = ~h; a = val; kill = k;
    step();
    mt_hi = 1'b0; mt_lo = 1'b0; kill = 1'b0; a = 32'h0;
  endtask

  initial begin
    logic seen;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    start = 1'b0; op = 2'b00; mt_hi = 1'b0; mt_lo = 1'b0;
    kill = 1'b0; a = '0; b = '0; d_mul_div = 1'b0;

    vecs[0] = '{"multu_ff", 2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0,
                32'h00000001, 32'hFFFFFFFE};
    vecs[1] = '{"mult_neg", 2'b00, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0,
                32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2] = '{"mult_max", 2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1,
                32'h3FFFFFFF, 32'h00000001};
    vecs[3] = '{"div_m7", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0,
                32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"divu_m7", 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0,
                32'h00000001, 32'h7FFFFFFC};
    vecs[5] = '{"div_7m2", 2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b1,
                32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{"div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0,
                32'h00000000, 32'h80000000};

    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    step();
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i]);
    end

    mt(1'b1, 32'h11, 1'b0);
    mt(1'b0, 32'h22, 1'b0);
    @(negedge clk);
    chk("mt.hi", 64'(hi), 64'h11);
    chk("mt.lo", 64'(lo), 64'h22);

    run_op('{"div0", 2'b10, 32'd99, 32'd0, 1'b1, 1'b0,
             32'h11, 32'h22});

    step();
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; kill = 1'b1;
    step();
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_start.busy", 64'(busy), 64'd0);
    repeat (6) step();
    @(negedge clk);
    chk("kill_start.hi", 64'(hi), 64'h11);
    chk("kill_start.lo", 64'(lo), 64'h22);

    mt(1'b1, 32'h55, 1'b1);
    @(negedge clk);
    chk("kill_mthi.busy", 64'(busy), 64'd0);
    chk("kill_mthi.hi", 64'(hi), 64'h11);

    mt(1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("mthi.hi", 64'(hi), 64'hDEADBEEF);
    chk("mthi.lo", 64'(lo), 64'h22);

    step();
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.hi", 64'(hi), 64'd0);
    chk("rst_mid.lo", 64'(lo), 64'd0);
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("rst_mid.no_done", 64'(seen), 64'd0);
    chk("rst_mid.lo_after", 64'(lo), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
